// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   state_t    : converter FSM states
//   DIGIT_W    : bits per BCD digit
//   ADJ_THRESH : digit value at or above which the double-dabble adjust applies
//   ADJ_INC    : value added to a digit by the adjust
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_INC    = 3;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit adjust: adds ADJ_INC to a BCD digit whose
// value is ADJ_THRESH or more, so the following left shift carries correctly.
//   din  : BCD digit before adjust
//   dout : BCD digit after adjust
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(ADJ_THRESH)) begin
      dout = din + DIGIT_W'(ADJ_INC);
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative binary-to-BCD converter (double dabble), one bit per clock, with
// valid/ready handshakes on both sides and a leading-zero blanking mask for
// the downstream seven-segment decoders.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : bin holds an operand
//   in_ready  : converter is idle and can accept an operand
//   bin       : unsigned binary operand
//   out_valid : bcd/blank hold a completed result
//   out_ready : consumer takes the result
//   bcd       : BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   blank     : blank[i] set when digit i and all higher digits are zero (i>=1)
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]         blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t            state;
  logic [WIDTH-1:0]  sreg;
  logic [BCD_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic [BCD_W-1:0]       acc_adj;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [BCD_W-1:0]       acc_next;
  logic [WIDTH-1:0]       sreg_next;

  // Leading-zero mask: walk from the top digit down, staying blank while
  // every digit seen so far is zero. Digit 0 always shows.
  function automatic logic [DIGITS-1:0] calc_blank(input logic [BCD_W-1:0] digits);
    logic [DIGITS-1:0] mask;
    logic              all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (digits[i*DIGIT_W +: DIGIT_W] == '0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (acc[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One double-dabble step: adjust, then shift {acc, operand} left by one.
  assign shifted   = {acc_adj, sreg} << 1;
  assign acc_next  = shifted[BCD_W+WIDTH-1:WIDTH];
  assign sreg_next = shifted[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      blank     <= BLANK_ZERO;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= bin;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg_next;
          acc  <= acc_next;
          cnt  <= cnt + 1'b1;
          // Last step: capture the result straight from the step logic so
          // bcd/blank are ready on the same edge out_valid rises.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bcd       <= acc_next;
            blank     <= calc_blank(acc_next);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed testbench for bin_to_bcd (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic [2:0]  blank;

  int tests;
  int fails;

  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operand for one edge; returns with the acceptance edge done.
  task automatic accept(input logic [7:0] value);
    bin      = value;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid; lat = -1 if it never comes.
  task automatic wait_result(output int lat, output bit rdy_seen);
    lat      = -1;
    rdy_seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      if (in_ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    tests++;
    if (bcd !== 12'h000) begin
      fails++; $display("FAIL reset_bcd got %h want 000", bcd);
    end
    tests++;
    if (blank !== 3'b110) begin
      fails++; $display("FAIL reset_blank got %b want 110", blank);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_max();
    int lat; bit rdy;
    out_ready = 1'b1;
    accept(8'd255);
    wait_result(lat, rdy);
    tests++;
    if (lat != 8) begin
      fails++; $display("FAIL max_latency got %0d want 8", lat);
    end
    tests++;
    if (bcd !== 12'h255 || blank !== 3'b000) begin
      fails++; $display("FAIL max_result got %h/%b want 255/000", bcd, blank);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL max_return got ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero();
    int lat; bit rdy;
    accept(8'd0);
    wait_result(lat, rdy);
    tests++;
    if (lat != 8 || bcd !== 12'h000 || blank !== 3'b110) begin
      fails++; $display("FAIL zero got lat=%0d %h/%b want 8 000/110", lat, bcd, blank);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat; bit rdy;
    accept(8'd100);
    wait_result(lat, rdy);
    tests++;
    if (rdy !== 1'b0) begin
      fails++; $display("FAIL b2b_in_ready got high during conversion want low");
    end
    tests++;
    if (lat != 8 || bcd !== 12'h100 || blank !== 3'b000) begin
      fails++; $display("FAIL b2b_first got lat=%0d %h/%b want 8 100/000", lat, bcd, blank);
    end
    @(posedge clk);
    #1;
    accept(8'd7);
    wait_result(lat, rdy);
    tests++;
    if (lat != 8 || bcd !== 12'h007 || blank !== 3'b110) begin
      fails++; $display("FAIL b2b_second got lat=%0d %h/%b want 8 007/110", lat, bcd, blank);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat; bit rdy;
    out_ready = 1'b0;
    accept(8'd42);
    wait_result(lat, rdy);
    tests++;
    if (lat != 8 || bcd !== 12'h042 || blank !== 3'b100) begin
      fails++; $display("FAIL bp_result got lat=%0d %h/%b want 8 042/100", lat, bcd, blank);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || bcd !== 12'h042 || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold cycle %0d got ov=%b bcd=%h ir=%b want 1/042/0", i, out_valid, bcd, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit rdy; bit pulsed;
    accept(8'd199);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || bcd !== 12'h000 || in_ready !== 1'b1) begin
      fails++; $display("FAIL abort_state got ov=%b bcd=%h ir=%b want 0/000/1", out_valid, bcd, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulsed = 1'b1;
    end
    tests++;
    if (pulsed) begin
      fails++; $display("FAIL abort_no_pulse got out_valid pulse want none");
    end
    accept(8'd9);
    wait_result(lat, rdy);
    tests++;
    if (lat != 8 || bcd !== 12'h009 || blank !== 3'b110) begin
      fails++; $display("FAIL abort_next got lat=%0d %h/%b want 8 009/110", lat, bcd, blank);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_input();
    bit seen;
    int lat;
    accept(8'd57);
    seen = 1'b0;
    lat  = -1;
    for (int n = 1; n <= 20 && !seen; n++) begin
      in_valid = n[0];
      bin      = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (lat != 8 || bcd !== 12'h057 || blank !== 3'b100) begin
      fails++; $display("FAIL ignore got lat=%0d %h/%b want 8 057/100", lat, bcd, blank);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL ignore_return got ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    bin       = '0;
    out_ready = 1'b1;
    test_reset();
    test_max();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_ignore_input();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
